// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared bus enums.
// Direction and status codes seen on rggen_bus_if.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: request/done register bus.
// The master holds request until it sees done.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);

  logic                     request;
  logic                     done;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   write_strobe;
  logic [BUS_WIDTH-1:0]     read_data;
  rggen_status              status;

  modport master (
    output request,
    output address,
    output direction,
    output write_data,
    output write_strobe,
    input  done,
    input  read_data,
    input  status
  );

  modport slave (
    input  request,
    input  address,
    input  direction,
    input  write_data,
    input  write_strobe,
    output done,
    output read_data,
    output status
  );

endinterface

// File: rtl/rggen_bus_storage_word.sv
// rggen_bus_storage_word: one storage word.
// Bytes with their strobe set take new data on a write.
module rggen_bus_storage_word #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_write,
  input  logic [DATA_WIDTH/8-1:0] i_strobe,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_value
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] value_q;

  // Per-byte strobed update; reset restores the initial value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= INITIAL_VALUE;
    end else if (i_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_strobe[b]) begin
          value_q[8*b+:8] <= i_data[8*b+:8];
        end
      end
    end
  end

  assign o_value = value_q;

endmodule

// File: rtl/rggen_external_bus_responder.sv
// rggen_external_bus_responder: bus target with a local word store.
// Accept, optional wait states, one-cycle done with status.
module rggen_external_bus_responder
  import rggen_rtl_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    WORDS         = 4,
  parameter int                    WAIT_CYCLES   = 0,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rggen_bus_if.slave                  bus_if,
  input  logic                        i_error,
  output logic [WORDS*DATA_WIDTH-1:0] o_word_value
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(BYTES);
  localparam int IW          = ADDRESS_WIDTH + 32;
  localparam logic [7:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_e;

  state_e                   state_q;
  logic [7:0]               count_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  rggen_direction           direction_q;
  logic [DATA_WIDTH-1:0]    write_data_q;
  logic [BYTES-1:0]         strobe_q;

  logic [IW-1:0]         index;
  logic                  in_range;
  logic                  respond;
  logic                  ok;
  logic                  commit;
  logic [DATA_WIDTH-1:0] word_sel;
  logic [DATA_WIDTH-1:0] words [WORDS];

  // Full-width index so high addresses never alias onto real words
  assign index    = IW'(address_q) >> OFFSET_BITS;
  assign in_range = index < IW'(WORDS);
  assign respond  = state_q == RESPOND;
  assign ok       = respond && in_range && !i_error;
  assign commit   = ok && (direction_q == RGGEN_WRITE);

  // Access sequencing; request is only looked at while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      address_q    <= '0;
      direction_q  <= RGGEN_READ;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus_if.request) begin
            address_q    <= bus_if.address;
            direction_q  <= bus_if.direction;
            write_data_q <= bus_if.write_data;
            strobe_q     <= bus_if.write_strobe;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              count_q <= WAIT_INIT;
            end else begin
              state_q <= RESPOND;
            end
          end
        end
        WAIT: begin
          if (count_q == 8'd0) begin
            state_q <= RESPOND;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        RESPOND: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read mux over the storage words
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (index == IW'(i)) begin
        word_sel = words[i];
      end
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    rggen_bus_storage_word #(
      .DATA_WIDTH    (DATA_WIDTH),
      .INITIAL_VALUE (INITIAL_VALUE)
    ) u_word (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_write  (commit && (index == IW'(g))),
      .i_strobe (strobe_q),
      .i_data   (write_data_q),
      .o_value  (words[g])
    );
    assign o_word_value[g*DATA_WIDTH+:DATA_WIDTH] = words[g];
  end

  assign bus_if.done      = respond;
  assign bus_if.read_data =
    (ok && (direction_q == RGGEN_READ)) ? word_sel : '0;
  assign bus_if.status    =
    (respond && !ok) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

endmodule
